// File: rtl/sys_defs.sv
// Shared system definitions: dispatch width, branch-mask width and the b_mask type.
`ifndef N
`define N 2
`endif
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package sys_defs;
    typedef logic [`B_MASK_WIDTH-1:0] B_MASK;
endpackage

// File: rtl/branch_age_matrix.sv
// Branch age matrix: row t holds the tags older than branch t; yields the squash set of a tag.
// Writes land one cycle after the request; the squash set is combinational from current state.
module branch_age_matrix #(
    parameter int W = `B_MASK_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [W-1:0]        wr_en_i,
    input  logic [W-1:0][W-1:0] wr_row_i,
    input  logic [W-1:0]        clr_set_i,
    input  logic [W-1:0]        query_tag_i,
    output logic [W-1:0]        squash_set_o
);
    logic [W-1:0][W-1:0] older_q, older_d;

    // Retired tags vanish from every row and column; fresh rows never reference them.
    always_comb begin
        older_d = older_q;
        for (int r = 0; r < W; r++) begin
            if (clr_set_i[r])
                older_d[r] = '0;
            else if (wr_en_i[r])
                older_d[r] = wr_row_i[r] & ~clr_set_i;
            else
                older_d[r] = older_q[r] & ~clr_set_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            older_q <= '0;
        else
            older_q <= older_d;
    end

    always_comb begin
        squash_set_o = query_tag_i;
        for (int u = 0; u < W; u++)
            if (|(older_q[u] & query_tag_i))
                squash_set_o[u] = 1'b1;
    end
endmodule

// File: rtl/psel_gen.sv
// Priority selector: grants the lowest-index set bit of the request vector.
// Purely combinational, no backpressure.
module psel_gen #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o
);
    // Two's-complement trick isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + WIDTH'(1));
endmodule

// File: rtl/branch_tag_ctrl.sv
// Branch tag allocator: hands out one-hot tags to dispatching branches, tracks outstanding tags, broadcasts clears/squashes.
// Grants are combinational from cur_mask; clear/squash pulses follow a resolve by one cycle; a full pool throttles dispatch.
module branch_tag_ctrl
    import sys_defs::*;
#(
    parameter int N = `N,
    parameter int W = `B_MASK_WIDTH,
    localparam int CW = $clog2(N+1),
    localparam int FW = $clog2(W+1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        alloc_req,
    input  logic [CW-1:0]       inst_valid,
    input  logic                resolve_valid,
    input  logic [W-1:0]        resolve_tag,
    input  logic                resolve_mispredict,
    output logic [N-1:0]        alloc_gnt,
    output logic [N-1:0][W-1:0] alloc_tag,
    output logic [N-1:0][W-1:0] alloc_mask,
    output logic [CW-1:0]       dispatch_allowed,
    output logic [W-1:0]        cur_mask,
    output logic [FW-1:0]       num_free,
    output logic                clear_valid,
    output logic [W-1:0]        clear_tag,
    output logic                squash_valid,
    output logic [W-1:0]        squash_mask
);
    logic [W-1:0]        cur_mask_q, cur_mask_d;
    logic                clear_valid_q, squash_valid_q;
    logic [W-1:0]        clear_tag_q, squash_mask_q;
    logic                res_ok, kill;
    logic [N:0][W-1:0]   pool;
    logic [N-1:0][W-1:0] pick;
    logic [N-1:0]        wants, gnt_raw;
    logic [W-1:0]        granted, squash_set, kill_set;
    logic [W-1:0][W-1:0] new_row;

    assign res_ok = resolve_valid && $onehot(resolve_tag) && (|(resolve_tag & cur_mask_q));
    assign kill   = res_ok && resolve_mispredict;

    // Tags freed by a same-cycle resolve are not in the pool until cur_mask updates.
    assign pool[0] = ~cur_mask_q;

    for (genvar i = 0; i < N; i++) begin : g_slot
        psel_gen #(.WIDTH(W)) u_psel (
            .req_i (pool[i]),
            .gnt_o (pick[i])
        );
        assign wants[i]      = alloc_req[i] && (CW'(i) < inst_valid);
        assign gnt_raw[i]    = wants[i] && (|pick[i]);
        assign pool[i+1]     = gnt_raw[i] ? (pool[i] & ~pick[i]) : pool[i];
        assign alloc_mask[i] = ~pool[i];
        assign alloc_gnt[i]  = gnt_raw[i] && !kill;
        assign alloc_tag[i]  = alloc_gnt[i] ? pick[i] : '0;
    end

    assign granted = kill ? '0 : (pool[0] & ~pool[N]);

    // Lowest starved branch slot caps dispatch; a live mispredict blocks everything.
    always_comb begin
        dispatch_allowed = inst_valid;
        for (int i = N-1; i >= 0; i--)
            if (wants[i] && !gnt_raw[i])
                dispatch_allowed = CW'(i);
        if (kill)
            dispatch_allowed = '0;
    end

    always_comb begin
        new_row = '0;
        for (int t = 0; t < W; t++)
            for (int i = 0; i < N; i++)
                if (alloc_tag[i][t])
                    new_row[t] = alloc_mask[i];
    end

    branch_age_matrix #(.W(W)) u_age (
        .clock        (clock),
        .reset        (reset),
        .wr_en_i      (granted),
        .wr_row_i     (new_row),
        .clr_set_i    (kill_set),
        .query_tag_i  (resolve_tag),
        .squash_set_o (squash_set)
    );

    assign kill_set   = kill ? squash_set : (res_ok ? resolve_tag : '0);
    assign cur_mask_d = (cur_mask_q & ~kill_set) | granted;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_mask_q     <= '0;
            clear_valid_q  <= 1'b0;
            clear_tag_q    <= '0;
            squash_valid_q <= 1'b0;
            squash_mask_q  <= '0;
        end else begin
            cur_mask_q     <= cur_mask_d;
            clear_valid_q  <= res_ok && !resolve_mispredict;
            clear_tag_q    <= (res_ok && !resolve_mispredict) ? resolve_tag : '0;
            squash_valid_q <= kill;
            squash_mask_q  <= kill ? squash_set : '0;
        end
    end

    assign cur_mask     = cur_mask_q;
    assign num_free     = FW'($countones(~cur_mask_q));
    assign clear_valid  = clear_valid_q;
    assign clear_tag    = clear_tag_q;
    assign squash_valid = squash_valid_q;
    assign squash_mask  = squash_mask_q;
endmodule

// File: doc/branch_tag_ctrl.md
BRANCH_TAG_CTRL -- requirements
Module: branch_tag_ctrl

Interface
REQ-001 Parameter N, default `N (2 for bench), dispatch width.
REQ-002 Parameter W, default `B_MASK_WIDTH (4 for bench), number of branch tags / branch-stack entries.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low (0 = reset).
REQ-005 alloc_req  in  N  slot i holds a branch wanting a tag; slot 0 oldest.
REQ-006 inst_valid  in  clog2(N+1)  count of valid dispatch slots (prefix).
REQ-007 resolve_valid  in  1  a branch resolves this cycle.
REQ-008 resolve_tag  in  W  one-hot tag of resolving branch.
REQ-009 resolve_mispredict  in  1  resolving branch mispredicted.
REQ-010 alloc_gnt  out  N  slot i received a tag this cycle.
REQ-011 alloc_tag  out  N x W  one-hot tag for slot i (0 when not granted).
REQ-012 alloc_mask  out  N x W  b_mask to attach to slot i: outstanding tags plus tags granted to slots < i.
REQ-013 dispatch_allowed  out  clog2(N+1)  slots permitted to dispatch this cycle.
REQ-014 cur_mask  out  W  registered outstanding-tag mask.
REQ-015 num_free  out  clog2(W+1)  popcount(~cur_mask).
REQ-016 clear_valid / clear_tag  out  1 / W  registered broadcast: tag retired correctly.
REQ-017 squash_valid / squash_mask  out  1 / W  registered broadcast: tags killed by mispredict.

Function
REQ-018 Allocation SHALL be combinational from cur_mask; free pool = ~cur_mask; tags freed by a same-cycle resolve SHALL NOT be reused until next cycle.
REQ-019 Branch slots SHALL be served in slot order, each taking the lowest-index remaining free tag.
REQ-020 First valid branch slot with no free tag SHALL stop allocation; dispatch_allowed = that slot index; otherwise dispatch_allowed = inst_valid.
REQ-021 Slots >= inst_valid SHALL be ignored (no grant).
REQ-022 If resolve_valid && resolve_mispredict with resolve_tag set in cur_mask, alloc_gnt SHALL be 0 and dispatch_allowed SHALL be 0 that cycle.
REQ-023 An age matrix older[t][u] SHALL be written on grant of tag t with alloc_mask of that slot, meaning u is older than t.
REQ-024 Correct resolve of tag t (t in cur_mask): next cur_mask clears t, column t cleared in every row, row t cleared; next cycle clear_valid=1, clear_tag=t.
REQ-025 Mispredict of tag t: squash set S = t plus every u with older[u][t]=1; next cur_mask = (cur_mask & ~S); rows/columns of S cleared; next cycle squash_valid=1, squash_mask=S.
REQ-026 Resolve of a tag not in cur_mask, or resolve_tag not one-hot, SHALL be ignored (no state change, no broadcast).
REQ-027 Simultaneous correct resolve and allocation: both apply; next cur_mask = (cur_mask & ~t) | granted tags; new rows SHALL exclude t.
REQ-028 clear_valid and squash_valid SHALL be single-cycle pulses, latency 1 after resolve.
REQ-029 Full: cur_mask all ones -> no grant, dispatch_allowed = index of first valid branch slot.

Reset
REQ-030 On reset low, cur_mask, age matrix, clear_*, squash_* SHALL be 0 immediately; num_free = W.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding tags with no broadcast.
REQ-032 Outputs SHALL be valid the first rising edge after reset deasserts.

Structure
REQ-033 B_MASK typedef, `B_MASK_WIDTH, `N SHALL come from the shared sys_defs package; no new package types.
REQ-034 Age matrix with squash-set computation SHALL be a sub-module branch_age_matrix.
REQ-035 Lowest-free-tag selection SHALL reuse the existing psel_gen.

Verification (N=2, W=4)
REQ-036 Reset, alloc_req=2'b11, inst_valid=2 -> alloc_tag={0010,0001}, alloc_mask={0001,0000}, dispatch_allowed=2; next cur_mask=0011.
REQ-037 cur_mask=0111, alloc_req=2'b11 -> slot0 gets 1000, slot1 no grant, dispatch_allowed=1; cur_mask=1111.
REQ-038 Tags allocated 0001,0010,0100 in order; mispredict tag 0010 -> next squash_valid=1, squash_mask=0110, cur_mask=0001.
REQ-039 cur_mask=1111, correct resolve 0100 with alloc_req=01 -> no grant that cycle; next clear_tag=0100, cur_mask=1011.
REQ-040 Mispredict with alloc_req=11 same cycle -> alloc_gnt=00, dispatch_allowed=0; resolve of unallocated tag -> no pulse, cur_mask unchanged.
REQ-041 Reset pulled low with cur_mask=0101 -> cur_mask=0000 asynchronously, no clear/squash pulse.
